// File: rtl/count8_display_pkg.sv
// Shared types and seven-segment constants for the count8 display stage.
package count8_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [1:0] digit_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Serial double-dabble converter: 8-bit binary to three BCD digits,
// one conversion every 10 cycles (capture, 8 shifts, write-back).
module bin2bcd8
  import count8_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  output logic [11:0] bcd,
  output logic        valid
);

  state_t      state;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [2:0]  bitcnt;
  logic [11:0] adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      bitcnt  <= '0;
      bcd     <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          shreg   <= din;
          scratch <= '0;
          bitcnt  <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // Adjust first, then shift; the final shift is never followed by an adjust
          {scratch, shreg} <= {adj[10:0], shreg, 1'b0};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd   <= scratch;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/count8_display.sv
// Count display: converts the counter value to BCD and scans it onto a
// common-anode 3-digit seven-segment display with optional leading-zero blanking.
module count8_display
  import count8_display_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  output logic [11:0] bcd,
  output logic        valid,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  digit_t        digit;
  logic [3:0]    nib;
  logic          blank;
  logic [2:0]    an_nx;

  bin2bcd8 u_conv (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .bcd   (bcd),
    .valid (valid)
  );

  // Scan timing: prescaler wrap advances the digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Digit select and blanking
  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    an_nx = 3'b110;
    case (digit)
      2'd1: begin
        nib   = bcd[7:4];
        blank = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        an_nx = 3'b101;
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0);
        an_nx = 3'b011;
      end
      default: ;
    endcase
  end

  // Output registers: seg and an update together so no mixed digit is shown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= 3'b111;
    end else begin
      seg <= blank ? SEG_BLANK : seg_decode(nib);
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_count8_display.sv
// Self-checking bench for count8_display: table vectors, corner sequences and
// randomized stimulus against a cycle-count based reference model.
module tb_count8_display;

  localparam int SCAN_DIV = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din   = 8'd0;
  logic [7:0]  din2  = 8'd7;
  logic [11:0] bcd, bcd2;
  logic        valid, valid2;
  logic [6:0]  seg, seg2;
  logic [2:0]  an, an2;

  always #5 clk = ~clk;

  count8_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .din(din), .bcd(bcd), .valid(valid), .seg(seg), .an(an)
  );

  count8_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .reset(reset), .din(din2), .bcd(bcd2), .valid(valid2), .seg(seg2), .an(an2)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state: edges since reset release, captured input, visible bcd
  int          k;
  logic [7:0]  cap;
  logic [11:0] bcd_m;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] bcd;
    logic [6:0]  su, st, sh;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int d, input bit blz);
    int h, t, u;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (d == 2) return (blz && h == 0) ? 7'h7F : segtab[h];
    if (d == 1) return (blz && h == 0 && t == 0) ? 7'h7F : segtab[t];
    return segtab[u];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t k=%0d: got %0h, want %0h", name, $time, k, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bcd"},   bcd,   12'h000);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_seg"},   seg,   7'h7F);
    chk({tag, "_an"},    an,    3'b111);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    k     = 0;
    bcd_m = 12'h000;
  endtask

  // One clock edge: advance the model from the spec's timing rules and compare
  task automatic tick();
    logic [7:0]  dsamp;
    logic [11:0] bprev;
    logic [2:0]  an_e;
    int          d;
    dsamp = din;
    @(posedge clk);
    #1;
    bprev = bcd_m;
    if (k % 10 == 0) cap = dsamp;
    if (k % 10 == 9) bcd_m = to_bcd(int'(cap));
    d    = (k / SCAN_DIV) % 3;
    an_e = 3'b111 ^ (3'b001 << d);
    chk("valid", valid, (k % 10 == 9));
    chk("bcd",   bcd,   bcd_m);
    chk("seg",   seg,   exp_seg(bprev, d, 1'b1));
    chk("an",    an,    an_e);
    k++;
  endtask

  initial begin
    logic [6:0] gu, gt, gh, nu, nt, nh;
    logic [7:0] cnt;
    int         vcount;

    vecs[0] = '{8'd0,   12'h000, 7'h40, 7'h7F, 7'h7F};
    vecs[1] = '{8'd255, 12'h255, 7'h12, 7'h12, 7'h24};
    vecs[2] = '{8'd100, 12'h100, 7'h40, 7'h40, 7'h79};
    vecs[3] = '{8'd7,   12'h007, 7'h78, 7'h7F, 7'h7F};
    vecs[4] = '{8'd10,  12'h010, 7'h40, 7'h79, 7'h7F};
    vecs[5] = '{8'd99,  12'h099, 7'h10, 7'h10, 7'h7F};
    vecs[6] = '{8'd208, 12'h208, 7'h00, 7'h40, 7'h24};
    vecs[7] = '{8'd63,  12'h063, 7'h30, 7'h02, 7'h7F};

    #2;
    // Table vectors: reset, hold din, check result and one full refresh
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      din = vecs[i].din;
      tick();
      chk("first_an",  an,  3'b110);
      chk("first_seg", seg, 7'h40);
      repeat (9) tick();
      chk("vec_bcd", bcd, vecs[i].bcd);
      tick();
      gu = 7'h55; gt = 7'h55; gh = 7'h55;
      nu = 7'h55; nt = 7'h55; nh = 7'h55;
      for (int j = 0; j < 3 * SCAN_DIV; j++) begin
        tick();
        case (an)
          3'b110: gu = seg;
          3'b101: gt = seg;
          3'b011: gh = seg;
          default: ;
        endcase
        case (an2)
          3'b110: nu = seg2;
          3'b101: nt = seg2;
          3'b011: nh = seg2;
          default: ;
        endcase
      end
      chk("vec_units", gu, vecs[i].su);
      chk("vec_tens",  gt, vecs[i].st);
      chk("vec_hund",  gh, vecs[i].sh);
      chk("nb_units",  nu, 7'h78);
      chk("nb_tens",   nt, 7'h40);
      chk("nb_hund",   nh, 7'h40);
      chk("nb_bcd",    bcd2, 12'h007);
    end

    // din changes mid-conversion are ignored until the next capture
    apply_reset();
    din = 8'd12;
    tick();
    din = 8'd200;
    repeat (9) tick();
    chk("inflight_bcd", bcd, 12'h012);
    repeat (10) tick();
    chk("next_bcd", bcd, 12'h200);

    // Reset during shift 4 aborts without publishing a result
    apply_reset();
    din = 8'd255;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    vcount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid) vcount++;
      chk("abort_hold_bcd", bcd, 12'h000);
    end
    chk("abort_valid_cnt", vcount, 0);
    reset = 1'b1;
    k     = 0;
    bcd_m = 12'h000;
    din   = 8'd0;
    repeat (20) tick();

    // Free-running counter source, starting near wrap
    apply_reset();
    cnt = 8'($urandom_range(240, 255));
    repeat (600) begin
      din = cnt;
      tick();
      cnt = cnt + 8'd1;
    end

    // Fully random input every cycle
    apply_reset();
    repeat (200) begin
      din = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count8_display.md
# count8_display

Display stage fed by the 8-bit up-counter: samples the binary count, converts it to three BCD digits with a serial shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a common-anode 3-digit seven-segment display with optional leading-zero blanking. Sits directly downstream of the counter's `cout` bus and drives board pins.

## Interface
- `SCAN_DIV`, 4: clock cycles each digit stays lit; legal range ≥1.
- `BLANK_LZ`, 1: 1 enables leading-zero blanking; 0 shows all three digits.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset; resets all state immediately.
- `din`  in  8  binary count from the counter stage.
- `bcd`  out  12  last converted value: [11:8] hundreds, [7:4] tens, [3:0] units.
- `valid`  out  1  one-cycle pulse when `bcd` updates.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  3  digit anodes, active-low one-hot: [0] units, [1] tens, [2] hundreds.

## Operation
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: capture `din` into shift register, clear scratch BCD and bit counter; go to SHIFT.
  - SHIFT: each cycle add 3 to any scratch BCD nibble ≥5, then shift {scratch,shreg} left by 1; after the 8th shift go to DONE.
  - DONE: `bcd` <= scratch, `valid` <= 1; go to IDLE.
- `din` is sampled only in IDLE; changes during SHIFT/DONE are ignored.
- Scratch width 12 bits; max input 255 gives 2/5/5, so no nibble ever exceeds 9.
- Scan: prescaler counts 0..SCAN_DIV-1 and wraps; on the wrap, the digit index advances 0→1→2→0.
- Seven-segment codes (active-low, g..a): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Nibbles >9 are unreachable; map them to 7'h7F.
- Blanking (BLANK_LZ=1): hundreds blank if hundreds==0; tens blank if hundreds==0 and tens==0; units never blank. A blanked digit drives `seg`=7'h7F and keeps its `an` bit asserted.
- `seg`/`an` are registered from the current digit index and `bcd`.

## Timing
- Reset values: FSM=IDLE, `bcd`=12'h000, `valid`=0, prescaler=0, digit index=0, `seg`=7'h7F, `an`=3'b111.
- Conversion period is fixed at 10 cycles: capture edge t0, shifts t1..t8, DONE edge t9 (updates `bcd`, sets `valid`), t10 clears `valid` and captures again.
- Latency from `din` sampled at t0 to `bcd` valid after t9: 9 cycles.
- `valid` is high exactly 1 cycle in every 10.
- The first edge after reset release drives `an`=3'b110 and `seg` for units of `bcd`=0 (7'h40).
- Each digit stays lit for SCAN_DIV cycles. Full refresh takes 3×SCAN_DIV cycles.
- `seg` and `an` change on the same edge; no cycle shows a mixed digit.
- Reset asserted mid-conversion: abort immediately to reset values. The partial result is never written to `bcd`.

## Structure
- Package `count8_display_pkg`: FSM state enum (IDLE/SHIFT/DONE), the ten segment constants, the blank constant 7'h7F, and the digit-index type.
- Sub-module `bin2bcd8`: serial converter holding the FSM, shift register, scratch, and bit counter. Ports: `clk`, `reset`, `din`, `bcd`, `valid`.
- Top level: prescaler, digit index, blanking, segment decode, output registers.

## Test plan
- Reset release with `din`=0: `an`=3'b110, `seg`=7'h40 on first edge; first `valid` pulse 9 cycles after capture with `bcd`=12'h000; tens/hundreds slots show 7'h7F.
- `din`=255 held: `bcd`=12'h255 after first `valid`; scan shows units 7'h12, tens 7'h12, hundreds 7'h24, each for SCAN_DIV cycles; `valid` period is exactly 10 cycles.
- `din`=100: `bcd`=12'h100; tens shows 7'h40 (not blanked); with BLANK_LZ=0 and `din`=7, all digits lit as 7'h40, 7'h40, 7'h78.
- Drive `din` from a free-running counter8 model: every `bcd` equals BCD of the counter value at the capture edge (every 10th count, wrapping 255→0 correctly).
- Change `din` from 12 to 200 during SHIFT: the in-flight result is 12'h012; the next conversion gives 12'h200.
- Assert `reset` at shift 4: all outputs return to reset values asynchronously; `valid` never pulses for the aborted conversion.
